// File: rtl/multiport_partitioned_ram_if.sv
// rtl/multiport_partitioned_ram_if.sv - request/response bundle for the multiport partitioned RAM
interface multiport_partitioned_ram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int NUM_PORTS  = 4,
    parameter int CNT_WIDTH  = 8
);
    logic [NUM_PORTS-1:0]            wr_en;
    logic [NUM_PORTS-1:0]            rd_en;
    logic [NUM_PORTS*DATA_WIDTH-1:0] data_in;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] address_in;
    logic [NUM_PORTS-1:0]            wr_ack;
    logic [NUM_PORTS-1:0]            wr_retry;
    logic [NUM_PORTS-1:0]            rd_valid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] rd_data;
    logic [NUM_PORTS-1:0]            err;
    logic [NUM_PORTS*CNT_WIDTH-1:0]  viol_count;

    // requesters drive the request side and observe responses
    modport master (
        output wr_en, rd_en, data_in, address_in,
        input  wr_ack, wr_retry, rd_valid, rd_data, err, viol_count
    );

    // the RAM consumes requests and drives every response register
    modport slave (
        input  wr_en, rd_en, data_in, address_in,
        output wr_ack, wr_retry, rd_valid, rd_data, err, viol_count
    );
endinterface

// File: rtl/multiport_partitioned_ram.sv
// rtl/multiport_partitioned_ram.sv - N-port RAM with private partitions, shared window and arbitration
module multiport_partitioned_ram #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 11,
    parameter int NUM_PORTS    = 4,
    parameter int SHARED_DEPTH = 256,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    multiport_partitioned_ram_if.slave     bus
);
    localparam int DEPTH       = 2 ** ADDR_WIDTH;
    localparam int SHARED_BASE = DEPTH - SHARED_DEPTH;
    localparam int P           = SHARED_BASE / NUM_PORTS;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // reject configurations whose address map cannot be split evenly
    if (NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_bad_ports
        $error("NUM_PORTS must be between 1 and 8");
    end
    if (SHARED_BASE % NUM_PORTS != 0) begin : g_bad_split
        $error("DEPTH-SHARED_DEPTH must be divisible by NUM_PORTS");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] addr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdata [NUM_PORTS];
    logic [NUM_PORTS-1:0]  in_shared;
    logic [NUM_PORTS-1:0]  legal;
    logic [NUM_PORTS-1:0]  wr_lose;
    logic [NUM_PORTS-1:0]  wr_go;
    logic [NUM_PORTS-1:0]  viol;

    // decode each port's address; read and write share one address, so one legality check covers both
    always_comb begin
        in_shared = '0;
        legal     = '0;
        wr_lose   = '0;
        wr_go     = '0;
        viol      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            addr[i]      = bus.address_in[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata[i]     = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
            in_shared[i] = (SHARED_DEPTH > 0) && (int'(addr[i]) >= SHARED_BASE);
            legal[i]     = in_shared[i] ||
                           ((int'(addr[i]) >= i * P) && (int'(addr[i]) < (i + 1) * P));
        end
        // lowest index wins a same-address shared write; private partitions cannot collide
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (j < i && bus.wr_en[j] && bus.wr_en[i] && in_shared[j] && in_shared[i] &&
                    addr[j] == addr[i]) begin
                    wr_lose[i] = 1'b1;
                end
            end
            wr_go[i] = bus.wr_en[i] && legal[i] && !wr_lose[i];
            viol[i]  = (bus.wr_en[i] || bus.rd_en[i]) && !legal[i];
        end
    end

    // memory array: no reset, and requests seen during reset are dropped
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (wr_go[i]) begin
                    mem[addr[i]] <= wdata[i];
                end
            end
        end
    end

    // response registers and saturating violation counters; reads sample pre-write contents
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.wr_ack     <= '0;
            bus.wr_retry   <= '0;
            bus.rd_valid   <= '0;
            bus.err        <= '0;
            bus.rd_data    <= '0;
            bus.viol_count <= '0;
        end else begin
            bus.wr_ack   <= wr_go;
            bus.wr_retry <= bus.wr_en & legal & wr_lose;
            bus.rd_valid <= bus.rd_en & legal;
            bus.err      <= viol;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (bus.rd_en[i]) begin
                    bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] <= legal[i] ? mem[addr[i]] : '0;
                end
                if (viol[i] && bus.viol_count[i*CNT_WIDTH +: CNT_WIDTH] != CNT_MAX) begin
                    bus.viol_count[i*CNT_WIDTH +: CNT_WIDTH] <=
                        bus.viol_count[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_multiport_partitioned_ram.sv
// tb/tb_multiport_partitioned_ram.sv - vector table plus scoreboard bench for multiport_partitioned_ram
module tb_multiport_partitioned_ram;
    localparam int NP = 4;
    localparam int DW = 8;
    localparam int AW = 11;
    localparam int CW = 8;

    typedef struct {
        string            name;
        logic [NP-1:0]    wr;
        logic [NP-1:0]    rd;
        logic [NP*DW-1:0] din;
        logic [NP*AW-1:0] addr;
        logic [NP-1:0]    e_ack;
        logic [NP-1:0]    e_retry;
        logic [NP-1:0]    e_valid;
        logic [NP-1:0]    e_err;
        logic [NP*DW-1:0] e_data;
        logic [NP*CW-1:0] e_viol;
    } vec_t;

    logic clk;
    logic reset_n;

    multiport_partitioned_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP), .CNT_WIDTH(CW)) bus ();

    multiport_partitioned_ram #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP), .SHARED_DEPTH(256), .CNT_WIDTH(CW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t          vecs[$];
    vec_t          sb[$];
    logic [DW-1:0] sh_rd   [NP];
    int            sh_viol [NP];
    int            n_cmp;
    int            n_bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t blank(input string n);
        vec_t v;
        v.name = n;
        v.wr = '0; v.rd = '0; v.din = '0; v.addr = '0;
        v.e_ack = '0; v.e_retry = '0; v.e_valid = '0; v.e_err = '0;
        v.e_data = '0; v.e_viol = '0;
        return v;
    endfunction

    // res: 0 = acked, 1 = retry, 2 = violation
    task automatic op_wr(inout vec_t v, input int p, input int a, input int d, input int res);
        v.wr[p] = 1'b1;
        v.addr[p*AW +: AW] = AW'(a);
        v.din[p*DW +: DW] = DW'(d);
        if (res == 0) v.e_ack[p] = 1'b1;
        else if (res == 1) v.e_retry[p] = 1'b1;
        else v.e_err[p] = 1'b1;
    endtask

    task automatic op_rd(inout vec_t v, input int p, input int a, input int exp, input bit ok);
        v.rd[p] = 1'b1;
        v.addr[p*AW +: AW] = AW'(a);
        if (ok) begin
            v.e_valid[p] = 1'b1;
            v.e_data[p*DW +: DW] = DW'(exp);
        end else begin
            v.e_err[p] = 1'b1;
        end
    endtask

    // fold held read data and saturating counts into the vector, then append it
    task automatic push_vec(input vec_t v);
        vec_t w;
        w = v;
        for (int p = 0; p < NP; p++) begin
            if (w.rd[p]) sh_rd[p] = w.e_valid[p] ? w.e_data[p*DW +: DW] : '0;
            w.e_data[p*DW +: DW] = sh_rd[p];
            if (w.e_err[p] && sh_viol[p] < 255) sh_viol[p]++;
            w.e_viol[p*CW +: CW] = CW'(sh_viol[p]);
        end
        vecs.push_back(w);
    endtask

    task automatic drive(input vec_t v);
        bus.wr_en      = v.wr;
        bus.rd_en      = v.rd;
        bus.data_in    = v.din;
        bus.address_in = v.addr;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " wr_ack"},     64'(bus.wr_ack),     64'd0);
        check({tag, " wr_retry"},   64'(bus.wr_retry),   64'd0);
        check({tag, " rd_valid"},   64'(bus.rd_valid),   64'd0);
        check({tag, " err"},        64'(bus.err),        64'd0);
        check({tag, " rd_data"},    64'(bus.rd_data),    64'd0);
        check({tag, " viol_count"}, 64'(bus.viol_count), 64'd0);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t e;
        string tag;
        n_cmp = 0;
        n_bad = 0;
        for (int p = 0; p < NP; p++) begin
            sh_rd[p] = '0;
            sh_viol[p] = 0;
        end

        v = blank("t1_wr");       op_wr(v, 0, 115, 8'hC3, 0); push_vec(v);
        v = blank("t1_rd");       op_rd(v, 0, 115, 8'hC3, 1); push_vec(v);
        v = blank("t2_wr");       op_wr(v, 1, 115, 8'h01, 2); push_vec(v);
        v = blank("t2_rd");       op_rd(v, 0, 115, 8'hC3, 1); push_vec(v);
        v = blank("t3_arb");      op_wr(v, 0, 1800, 8'hAA, 0); op_wr(v, 2, 1800, 8'h55, 1); push_vec(v);
        v = blank("t3_rd");       op_rd(v, 3, 1800, 8'hAA, 1); push_vec(v);
        v = blank("t3_retry");    op_wr(v, 2, 1800, 8'h55, 0); push_vec(v);
        v = blank("t3_rd2");      op_rd(v, 2, 1800, 8'h55, 1); push_vec(v);
        v = blank("diff_shared"); op_wr(v, 1, 1900, 8'h77, 0); op_wr(v, 3, 1901, 8'h88, 0); push_vec(v);
        v = blank("cross_rw");    op_wr(v, 0, 1900, 8'h99, 0); op_rd(v, 1, 1900, 8'h77, 1);
                                  op_rd(v, 3, 1901, 8'h88, 1); push_vec(v);
        v = blank("cross_rd");    op_rd(v, 1, 1900, 8'h99, 1); push_vec(v);
        v = blank("t4_wr");       op_wr(v, 1, 500, 8'h11, 0); push_vec(v);
        v = blank("t4_rdwr");     op_wr(v, 1, 500, 8'h22, 0); op_rd(v, 1, 500, 8'h11, 1); push_vec(v);
        v = blank("t4_rd");       op_rd(v, 1, 500, 8'h22, 1); push_vec(v);
        v = blank("idle");        push_vec(v);
        v = blank("rw_bad");      op_wr(v, 1, 0, 8'hEE, 2); op_rd(v, 1, 0, 0, 0); push_vec(v);
        v = blank("bounds_lo");   op_wr(v, 0, 447, 8'h5A, 0); op_wr(v, 1, 448, 8'hA5, 0);
                                  op_wr(v, 3, 1791, 8'h3C, 0); push_vec(v);
        v = blank("bounds_hi");   op_rd(v, 0, 448, 0, 0); op_rd(v, 1, 447, 0, 0);
                                  op_rd(v, 3, 1791, 8'h3C, 1); op_wr(v, 2, 2047, 8'hE7, 0); push_vec(v);
        v = blank("bounds_rd");   op_rd(v, 0, 447, 8'h5A, 1); op_rd(v, 1, 448, 8'hA5, 1);
                                  op_rd(v, 3, 2047, 8'hE7, 1); op_wr(v, 2, 1343, 8'h66, 0); push_vec(v);
        v = blank("arb3");        op_wr(v, 1, 2000, 8'h10, 0); op_wr(v, 2, 2000, 8'h20, 1);
                                  op_wr(v, 3, 2000, 8'h30, 1); op_wr(v, 0, 1343, 8'h01, 2); push_vec(v);
        v = blank("arb3_rd");     op_rd(v, 0, 2000, 8'h10, 1); op_rd(v, 2, 1343, 8'h66, 1); push_vec(v);
        for (int k = 0; k < 300; k++) begin
            v = blank($sformatf("sat%0d", k));
            op_rd(v, 3, 0, 0, 0);
            push_vec(v);
        end

        // reset state
        reset_n = 1'b0;
        drive(blank("none"));
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // table vectors through the scoreboard
        foreach (vecs[k]) begin
            drive(vecs[k]);
            sb.push_back(vecs[k]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            tag = $sformatf("v%0d %s", k, e.name);
            check({tag, " wr_ack"},     64'(bus.wr_ack),     64'(e.e_ack));
            check({tag, " wr_retry"},   64'(bus.wr_retry),   64'(e.e_retry));
            check({tag, " rd_valid"},   64'(bus.rd_valid),   64'(e.e_valid));
            check({tag, " err"},        64'(bus.err),        64'(e.e_err));
            check({tag, " rd_data"},    64'(bus.rd_data),    64'(e.e_data));
            check({tag, " viol_count"}, 64'(bus.viol_count), 64'(e.e_viol));
        end

        // asynchronous reset in the middle of a port2 legal write
        v = blank("rst_wr");
        op_wr(v, 2, 1000, 8'h42, 0);
        drive(v);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        drive(blank("none"));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_zero("post_release");

        v = blank("rst_rd");
        op_rd(v, 2, 1800, 8'h55, 1);
        drive(v);
        @(posedge clk);
        #1;
        drive(blank("none"));
        check("post_reset rd_valid", 64'(bus.rd_valid), 64'(4'b0100));
        check("post_reset rd_data2", 64'(bus.rd_data[2*DW +: DW]), 64'h55);
        check("post_reset err", 64'(bus.err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
